// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM-stage port (A), the loader/debug port (B) and the data memory.
// The slave modport is the arbiter's view of the bundle; the master modport is the view from the surrounding logic.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  aRead;
  logic                  aWrite;
  logic [ADDR_WIDTH-1:0] aAddress;
  logic [DATA_WIDTH-1:0] aWriteData;
  logic [DATA_WIDTH-1:0] aDataRead;
  logic                  aReady;
  logic                  stall;
  logic                  bReq;
  logic                  bWrite;
  logic [ADDR_WIDTH-1:0] bAddress;
  logic [DATA_WIDTH-1:0] bWriteData;
  logic [DATA_WIDTH-1:0] bDataRead;
  logic                  bAck;
  logic                  memRead;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic [DATA_WIDTH-1:0] memDataRead;

  modport slave (
    input  aRead, aWrite, aAddress, aWriteData,
    output aDataRead, aReady, stall,
    input  bReq, bWrite, bAddress, bWriteData,
    output bDataRead, bAck,
    output memRead, memWrite, memAddress, memWriteData,
    input  memDataRead
  );

  modport master (
    output aRead, aWrite, aAddress, aWriteData,
    input  aDataRead, aReady, stall,
    output bReq, bWrite, bAddress, bWriteData,
    input  bDataRead, bAck,
    input  memRead, memWrite, memAddress, memWriteData,
    output memDataRead
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the MEM stage (A) and the loader (B).
// Each access is one latched request, one strobe cycle, LATENCY wait cycles, then a one-cycle completion pulse.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LATENCY    = 1
) (
  input  logic            clock,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q,      state_d;
  logic                  last_a_q,     last_a_d;
  logic                  own_a_q,      own_a_d;
  logic                  op_write_q,   op_write_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic                  mem_read_q,   mem_read_d;
  logic                  mem_write_q,  mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
  logic [DATA_WIDTH-1:0] a_rdata_q,    a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q,    b_rdata_d;
  logic                  a_ready_q,    a_ready_d;
  logic                  b_ack_q,      b_ack_d;

  logic req_a_c;
  logic req_b_c;
  logic grant_a_c;
  logic grant_write_c;

  assign req_a_c       = bus.aRead | bus.aWrite;
  assign req_b_c       = bus.bReq;
  // On a tie the port that did not win last time is served.
  assign grant_a_c     = req_a_c & (~req_b_c | ~last_a_q);
  assign grant_write_c = grant_a_c ? bus.aWrite : bus.bWrite;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      last_a_q    <= 1'b0;
      own_a_q     <= 1'b0;
      op_write_q  <= 1'b0;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_ready_q   <= 1'b0;
      b_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_a_q    <= last_a_d;
      own_a_q     <= own_a_d;
      op_write_q  <= op_write_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_ready_q   <= a_ready_d;
      b_ack_q     <= b_ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_a_d    = last_a_q;
    own_a_d     = own_a_q;
    op_write_d  = op_write_q;
    cnt_d       = cnt_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_ready_d   = 1'b0;
    b_ack_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_a_c | req_b_c) begin
          own_a_d     = grant_a_c;
          last_a_d    = grant_a_c;
          op_write_d  = grant_write_c;
          mem_addr_d  = grant_a_c ? bus.aAddress   : bus.bAddress;
          mem_wdata_d = grant_a_c ? bus.aWriteData : bus.bWriteData;
          mem_read_d  = ~grant_write_c;
          mem_write_d = grant_write_c;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = WAIT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // Read data is only valid in the final wait cycle.
        if (cnt_q == '0) begin
          if (!op_write_q) begin
            if (own_a_q) a_rdata_d = bus.memDataRead;
            else         b_rdata_d = bus.memDataRead;
          end
          a_ready_d = own_a_q;
          b_ack_d   = ~own_a_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.memRead      = mem_read_q;
  assign bus.memWrite     = mem_write_q;
  assign bus.memAddress   = mem_addr_q;
  assign bus.memWriteData = mem_wdata_q;
  assign bus.aDataRead    = a_rdata_q;
  assign bus.aReady       = a_ready_q;
  assign bus.bDataRead    = b_rdata_q;
  assign bus.bAck         = b_ack_q;
  assign bus.stall        = req_a_c & ~a_ready_q & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance at LATENCY=1 (index 0) and one at LATENCY=4 (index 1),
// checked every cycle against a transaction-timeline model plus hand-computed checkpoints.
module tb_dmem_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        rst [2];
  logic        a_rd [2], a_wr [2], b_req [2], b_wr [2];
  logic [15:0] a_addr [2], a_wdata [2], b_addr [2], b_wdata [2], mem_rd [2];

  logic        o_mr [2], o_mw [2], o_ar [2], o_ba [2], o_st [2];
  logic [15:0] o_ma [2], o_mwd [2], o_ad [2], o_bd [2];

  // Timeline model: a grant at cycle n fixes strobe, capture, pulse and next-idle cycles.
  bit          armed [2], act [2], own_a [2], wr [2], last_a [2];
  int          t_issue [2], t_win [2], t_done [2], free_at [2];
  logic [15:0] e_addr [2], e_wdata [2], e_ard [2], e_brd [2];

  int          ar_cyc [2], ba_cyc [2], mr_cyc [2], mw_cyc [2], ar_n [2], ba_n [2], st_n [2];
  logic [15:0] mw_addr [2], mw_data [2];
  logic [15:0] mem [256];

  dmem_arbiter_if if1 ();
  dmem_arbiter_if if4 ();

  dmem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(rst[0]), .bus(if1.slave));
  dmem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .LATENCY(4)) u_l4 (
    .clock(clock), .reset(rst[1]), .bus(if4.slave));

  assign if1.aRead = a_rd[0];   assign if1.aWrite = a_wr[0];
  assign if1.aAddress = a_addr[0];  assign if1.aWriteData = a_wdata[0];
  assign if1.bReq = b_req[0];   assign if1.bWrite = b_wr[0];
  assign if1.bAddress = b_addr[0];  assign if1.bWriteData = b_wdata[0];
  assign if1.memDataRead = mem_rd[0];
  assign o_mr[0] = if1.memRead;  assign o_mw[0] = if1.memWrite;
  assign o_ma[0] = if1.memAddress;  assign o_mwd[0] = if1.memWriteData;
  assign o_ad[0] = if1.aDataRead;  assign o_bd[0] = if1.bDataRead;
  assign o_ar[0] = if1.aReady;  assign o_ba[0] = if1.bAck;  assign o_st[0] = if1.stall;

  assign if4.aRead = a_rd[1];   assign if4.aWrite = a_wr[1];
  assign if4.aAddress = a_addr[1];  assign if4.aWriteData = a_wdata[1];
  assign if4.bReq = b_req[1];   assign if4.bWrite = b_wr[1];
  assign if4.bAddress = b_addr[1];  assign if4.bWriteData = b_wdata[1];
  assign if4.memDataRead = mem_rd[1];
  assign o_mr[1] = if4.memRead;  assign o_mw[1] = if4.memWrite;
  assign o_ma[1] = if4.memAddress;  assign o_mwd[1] = if4.memWriteData;
  assign o_ad[1] = if4.aDataRead;  assign o_bd[1] = if4.bDataRead;
  assign o_ar[1] = if4.aReady;  assign o_ba[1] = if4.bAck;  assign o_st[1] = if4.stall;

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s lat_idx=%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_step(input int k, input int lat);
    bit ga;
    if (rst[k]) begin
      armed[k] = 1'b1;  act[k] = 1'b0;  last_a[k] = 1'b0;  free_at[k] = cyc + 1;
      e_addr[k] = '0;  e_wdata[k] = '0;  e_ard[k] = '0;  e_brd[k] = '0;
      return;
    end
    if (act[k] && cyc == t_win[k] && !wr[k]) begin
      if (own_a[k]) e_ard[k] = mem_rd[k];
      else          e_brd[k] = mem_rd[k];
    end
    if (cyc >= free_at[k] && (a_rd[k] || a_wr[k] || b_req[k])) begin
      ga = (a_rd[k] || a_wr[k]) && (!b_req[k] || !last_a[k]);
      last_a[k]  = ga;
      own_a[k]   = ga;
      wr[k]      = ga ? a_wr[k] : b_wr[k];
      e_addr[k]  = ga ? a_addr[k] : b_addr[k];
      e_wdata[k] = ga ? a_wdata[k] : b_wdata[k];
      act[k]     = 1'b1;
      t_issue[k] = cyc + 1;
      t_win[k]   = cyc + 1 + lat;
      t_done[k]  = cyc + 2 + lat;
      free_at[k] = cyc + 3 + lat;
    end
  endtask

  // Memory returns real data only in the final wait cycle, garbage otherwise.
  always @(posedge clock) begin
    #1;
    for (int k = 0; k < 2; k++)
      mem_rd[k] = (act[k] && cyc == t_win[k]) ? mem[e_addr[k][7:0]] : (16'hDEAD ^ 16'(cyc));
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (armed[k]) begin
        chk("memRead",      k, 32'(o_mr[k]),  32'(act[k] && cyc == t_issue[k] && !wr[k]));
        chk("memWrite",     k, 32'(o_mw[k]),  32'(act[k] && cyc == t_issue[k] && wr[k]));
        chk("memAddress",   k, 32'(o_ma[k]),  32'(e_addr[k]));
        chk("memWriteData", k, 32'(o_mwd[k]), 32'(e_wdata[k]));
        chk("aDataRead",    k, 32'(o_ad[k]),  32'(e_ard[k]));
        chk("bDataRead",    k, 32'(o_bd[k]),  32'(e_brd[k]));
        chk("aReady",       k, 32'(o_ar[k]),  32'(act[k] && cyc == t_done[k] && own_a[k]));
        chk("bAck",         k, 32'(o_ba[k]),  32'(act[k] && cyc == t_done[k] && !own_a[k]));
        chk("stall",        k, 32'(o_st[k]),
            32'((a_rd[k] || a_wr[k]) && !(act[k] && cyc == t_done[k] && own_a[k]) && !rst[k]));
      end
      if (o_ar[k] === 1'b1) begin ar_cyc[k] = cyc; ar_n[k]++; end
      if (o_ba[k] === 1'b1) begin ba_cyc[k] = cyc; ba_n[k]++; end
      if (o_st[k] === 1'b1) st_n[k]++;
      if (o_mr[k] === 1'b1) mr_cyc[k] = cyc;
      if (o_mw[k] === 1'b1) begin mw_cyc[k] = cyc; mw_addr[k] = o_ma[k]; mw_data[k] = o_mwd[k]; end
      model_step(k, (k == 0) ? 1 : 4);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257);
    mem[8'h10] = 16'hBEEF;
    mem[8'h20] = 16'hCAFE;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;  a_rd[k] = 1'b0;  a_wr[k] = 1'b0;  b_req[k] = 1'b0;  b_wr[k] = 1'b0;
      a_addr[k] = '0;  a_wdata[k] = '0;  b_addr[k] = '0;  b_wdata[k] = '0;  mem_rd[k] = '0;
      armed[k] = 1'b0;  act[k] = 1'b0;  own_a[k] = 1'b0;  wr[k] = 1'b0;  last_a[k] = 1'b0;
      t_issue[k] = -1;  t_win[k] = -1;  t_done[k] = -1;  free_at[k] = 0;
      e_addr[k] = '0;  e_wdata[k] = '0;  e_ard[k] = '0;  e_brd[k] = '0;
      ar_cyc[k] = -1;  ba_cyc[k] = -1;  mr_cyc[k] = -1;  mw_cyc[k] = -1;
      ar_n[k] = 0;  ba_n[k] = 0;  st_n[k] = 0;  mw_addr[k] = '0;  mw_data[k] = '0;
    end
    tick(3);
    rst[0] = 1'b0;  rst[1] = 1'b0;
    tick(4);
    for (int k = 0; k < 2; k++) begin
      chk("idle_no_read_strobe",  k, 32'(mr_cyc[k]), 32'(-1));
      chk("idle_no_write_strobe", k, 32'(mw_cyc[k]), 32'(-1));
      chk("idle_no_pulse",        k, 32'(ar_n[k] + ba_n[k]), 32'd0);
    end

    // LATENCY=1: lone A read of 0x0010
    n = cyc;  st_n[0] = 0;
    a_rd[0] = 1'b1;  a_addr[0] = 16'h0010;
    tick(4);
    a_rd[0] = 1'b0;
    chk("a_read_strobe_cyc", 0, 32'(mr_cyc[0] - n), 32'd1);
    chk("a_read_ready_cyc",  0, 32'(ar_cyc[0] - n), 32'd3);
    chk("a_read_data",       0, 32'(o_ad[0]), 32'h0000BEEF);
    chk("a_read_stall_len",  0, 32'(st_n[0]), 32'd3);

    // LATENCY=1: B write 0x1234 to 0x00FF
    tick(2);
    n = cyc;
    b_req[0] = 1'b1;  b_wr[0] = 1'b1;  b_addr[0] = 16'h00FF;  b_wdata[0] = 16'h1234;
    tick(4);
    b_req[0] = 1'b0;  b_wr[0] = 1'b0;
    chk("b_write_strobe_cyc", 0, 32'(mw_cyc[0] - n), 32'd1);
    chk("b_write_addr",       0, 32'(mw_addr[0]), 32'h000000FF);
    chk("b_write_data",       0, 32'(mw_data[0]), 32'h00001234);
    chk("b_write_ack_cyc",    0, 32'(ba_cyc[0] - n), 32'd3);
    chk("b_write_rdata_kept", 0, 32'(o_bd[0]), 32'd0);

    // LATENCY=1: both ports requesting from reset, alternating grants
    tick(1);
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    n = cyc;  ar_n[0] = 0;  ba_n[0] = 0;  st_n[0] = 0;
    a_rd[0] = 1'b1;  a_addr[0] = 16'h0020;
    b_req[0] = 1'b1;  b_wr[0] = 1'b0;  b_addr[0] = 16'h0010;
    tick(12);
    a_rd[0] = 1'b0;
    tick(4);
    b_req[0] = 1'b0;
    chk("tie_a_count",    0, 32'(ar_n[0]), 32'd2);
    chk("tie_b_count",    0, 32'(ba_n[0]), 32'd2);
    chk("tie_a_last_cyc", 0, 32'(ar_cyc[0] - n), 32'd11);
    chk("tie_b_last_cyc", 0, 32'(ba_cyc[0] - n), 32'd15);
    chk("tie_a_stall",    0, 32'(st_n[0]), 32'd10);
    chk("tie_a_data",     0, 32'(o_ad[0]), 32'h0000CAFE);
    chk("tie_b_data",     0, 32'(o_bd[0]), 32'h0000BEEF);

    // LATENCY=4: A read ignoring garbage before the last wait cycle
    n = cyc;  st_n[1] = 0;
    a_rd[1] = 1'b1;  a_addr[1] = 16'h0010;
    tick(7);
    a_rd[1] = 1'b0;
    chk("l4_strobe_cyc", 1, 32'(mr_cyc[1] - n), 32'd1);
    chk("l4_ready_cyc",  1, 32'(ar_cyc[1] - n), 32'd6);
    chk("l4_read_data",  1, 32'(o_ad[1]), 32'h0000BEEF);
    chk("l4_stall_len",  1, 32'(st_n[1]), 32'd6);

    // LATENCY=4: reset during WAIT, then the held request completes
    tick(2);
    n = cyc;  ar_n[1] = 0;
    a_rd[1] = 1'b1;  a_addr[1] = 16'h0020;
    tick(3);
    rst[1] = 1'b1;
    tick(1);
    rst[1] = 1'b0;
    chk("rst_wait_data_cleared", 1, 32'(o_ad[1]), 32'd0);
    chk("rst_wait_no_pulse",     1, 32'(ar_n[1]), 32'd0);
    tick(7);
    a_rd[1] = 1'b0;
    chk("rerequest_count", 1, 32'(ar_n[1]), 32'd1);
    chk("rerequest_cyc",   1, 32'(ar_cyc[1] - n), 32'd10);
    chk("rerequest_data",  1, 32'(o_ad[1]), 32'h0000CAFE);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 16-bit data memory between the pipeline's MEM-stage port (A) and a loader/debug port (B). It latches one request, drives one memory command, waits a parameterised read latency and returns read data with a one-cycle completion pulse. While a port-A access is outstanding it stalls the pipeline. It sits between the MEM stage and the data memory and replaces the direct MEM-to-memory connection.

## Interface
- DATA_WIDTH, 16, data word width
- ADDR_WIDTH, 16, address width
- LATENCY, 1, memory read latency in cycles (legal 1..7)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- aRead, aWrite  in  1 each  port A read/write request; both high means write
- aAddress  in  ADDR_WIDTH  port A address
- aWriteData  in  DATA_WIDTH  port A write data
- aDataRead  out  DATA_WIDTH  port A read data (registered)
- aReady  out  1  port A completion pulse
- stall  out  1  pipeline hold: A requesting and not completing
- bReq, bWrite  in  1 each  port B request; op select (1 = write)
- bAddress  in  ADDR_WIDTH  port B address
- bWriteData  in  DATA_WIDTH  port B write data
- bDataRead  out  DATA_WIDTH  port B read data (registered)
- bAck  out  1  port B completion pulse
- memRead, memWrite  out  1 each  memory strobes
- memAddress  out  ADDR_WIDTH  memory address (registered)
- memWriteData  out  DATA_WIDTH  memory write data (registered)
- memDataRead  in  DATA_WIDTH  memory read data

## Operation
- A requests when aRead|aWrite. B requests when bReq. A requester holds its request and operands stable until its completion pulse and drops them no later than the cycle after.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request is pending, arbitrate, latch owner, op, address and write data, then go to ISSUE. Otherwise stay in IDLE.
- Arbitration: a single requester is granted. On a tie, grant goes to the port not granted last (round-robin). lastGrant resets to B, so A wins the first tie.
- ISSUE (1 cycle): exactly one of memRead/memWrite is high. memAddress and memWriteData carry the latched values. Next state is WAIT.
- WAIT (LATENCY cycles, counted by a 3-bit counter): strobes are low. memAddress and memWriteData hold. memDataRead is valid during the last WAIT cycle. For a read, that value is registered into the owner's DataRead at the edge ending WAIT. Next state is DONE.
- DONE (1 cycle): aReady or bAck is high for the owner only. Next state is always IDLE, so the still-asserted request is not re-granted.
- DataRead registers change only on the owner's read completion. Writes leave both unchanged.
- stall = (aRead|aWrite) & ~aReady & ~reset. It is combinational and high while B owns the memory and A is waiting.
- Operand changes after latching are ignored.
- Reset values: state IDLE; lastGrant B; all strobes, acks, counter, memAddress, memWriteData, aDataRead and bDataRead are 0.
- Reset mid-transaction: the FSM returns to IDLE at the next edge and no completion pulse is generated. A write whose ISSUE cycle has already completed is considered performed.

## Timing
- A request first sampled in IDLE at cycle n gives: ISSUE at n+1, WAIT at n+2 .. n+1+LATENCY, DONE at n+2+LATENCY, IDLE at n+3+LATENCY.
- Access latency is LATENCY+2 cycles after the request cycle. Throughput is one access per LATENCY+3 cycles.
- A lone A access stalls the pipeline for LATENCY+2 cycles.
- If A loses a tie, it is additionally stalled for LATENCY+3 cycles.
- The strobe is high for exactly 1 cycle per access and never high outside ISSUE.

## Test plan
- Reset, then idle: all outputs 0, stall 0, memory strobes never asserted.
- LATENCY=1, A read at 0x0010 with memory returning 0xBEEF: memRead high for one cycle at n+1; aReady at n+3 with aDataRead=0xBEEF; stall high n..n+2.
- B write of 0x1234 to 0x00FF: memWrite high one cycle with memAddress=0x00FF and memWriteData=0x1234; bAck at n+3; bDataRead unchanged.
- A and B requesting simultaneously from reset, both held: A served first, then B, then A. Grants alternate and no port is starved; A's stall covers B's access.
- LATENCY=4, A read: aReady at n+6; memDataRead is sampled only in the last WAIT cycle (garbage driven earlier is not captured).
- Reset asserted during WAIT of an A read: IDLE next cycle, no aReady, aDataRead=0. A re-request completes normally.
